// File: rtl/complement_scheduler_pkg.sv
// Shared definitions for the two-requester complement scheduler.
// Holds the default width, the operation encoding and the FSM state codes.
package complement_scheduler_pkg;

  localparam int W_DEFAULT = 6;
  localparam int NUM_REQ   = 2;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_NEG  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NEG  = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/complement_scheduler_if.sv
// Request/response bundle between two requesters and the complement scheduler.
// The master side drives requests and accepts responses; the slave side is the scheduler.
interface complement_scheduler_if
  import complement_scheduler_pkg::*;
#(
  parameter int W = W_DEFAULT
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0][1:0]   req_op;
  logic [NUM_REQ-1:0][W-1:0] req_a;
  logic [NUM_REQ-1:0][W-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_id;
  logic [W-1:0]              rsp_result;
  logic                      rsp_overflow;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );

endinterface

// File: rtl/complement_scheduler_neg_unit.sv
// Two's complement negator (~x + 1, wrapping) with a flag for the most-negative
// operand, whose negation is not representable in W bits.
module neg_unit
  import complement_scheduler_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         is_min
);

  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  assign y      = ~x + ONE;
  assign is_min = (x == MOST_NEG);

endmodule

// File: rtl/complement_scheduler.sv
// Round-robin scheduler serving two requesters with PASS/NEG/ADD/SUB on W-bit
// two's complement operands through one shared negator; one op every 4 cycles.
module complement_scheduler
  import complement_scheduler_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  complement_scheduler_if.slave bus
);

  logic [1:0]         state_reg, state_next;
  logic               last_reg;
  logic               id_reg;
  op_e                op_reg;
  logic [W-1:0]       a_reg, b_reg, result_reg;
  logic               ovf_reg, neg_ovf_reg;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready_vec;
  logic               accept;
  logic               sel;
  logic [W-1:0]       neg_out;
  logic               neg_min;
  logic [W-1:0]       sum;
  logic               add_ovf;
  logic [W-1:0]       result_next;
  logic               ovf_next;

  neg_unit #(.W(W)) u_neg (
    .x      (b_reg),
    .y      (neg_out),
    .is_min (neg_min)
  );

  // On a tie the requester not served last wins; last_reg resets to 1 so req 0 wins first.
  always_comb begin
    grant = '0;
    case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_reg ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign ready_vec[gi] = (state_reg == ST_IDLE) && grant[gi];
  end

  assign accept = |(bus.req_valid & ready_vec);
  assign sel    = grant[1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_NEG;
      ST_NEG:  state_next = ST_ADD;
      ST_ADD:  state_next = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // b_reg already holds the negated operand for SUB, so ADD and SUB share one adder.
  assign sum     = a_reg + b_reg;
  assign add_ovf = (a_reg[W-1] == b_reg[W-1]) && (sum[W-1] != a_reg[W-1]);

  always_comb begin
    result_next = a_reg;
    ovf_next    = 1'b0;
    case (op_reg)
      OP_NEG: begin
        result_next = b_reg;
        ovf_next    = neg_ovf_reg;
      end
      OP_ADD, OP_SUB: begin
        result_next = sum;
        ovf_next    = add_ovf;
      end
      default: begin
        result_next = a_reg;
        ovf_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      last_reg    <= 1'b1;
      id_reg      <= 1'b0;
      op_reg      <= OP_PASS;
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      ovf_reg     <= 1'b0;
      neg_ovf_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg   <= op_e'(bus.req_op[sel]);
            a_reg    <= bus.req_a[sel];
            b_reg    <= bus.req_b[sel];
            id_reg   <= sel;
            last_reg <= sel;
          end
        end
        ST_NEG: begin
          if (op_reg == OP_NEG || op_reg == OP_SUB) begin
            b_reg <= neg_out;
          end
          neg_ovf_reg <= neg_min;
        end
        ST_ADD: begin
          result_reg <= result_next;
          ovf_reg    <= ovf_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = ready_vec;
  assign bus.rsp_valid    = (state_reg == ST_RESP);
  assign bus.rsp_id       = id_reg;
  assign bus.rsp_result   = result_reg;
  assign bus.rsp_overflow = ovf_reg;

endmodule

// File: tb/tb_complement_scheduler.sv
// Self-checking bench for complement_scheduler: directed corner cases plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_complement_scheduler;

  localparam int W = 6;
  localparam int MAXV = (1 << (W-1)) - 1;
  localparam int MINV = -(1 << (W-1));
  localparam logic [W-1:0] MIN_BITS = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_BITS = {1'b0, {(W-1){1'b1}}};

  logic clk;
  logic rst_n;

  complement_scheduler_if #(.W(W)) bus ();

  complement_scheduler #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sval(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] res, output logic ovf);
    int t;
    int nb_int;
    logic [W-1:0] nb;
    case (op)
      2'b00: t = sval(a);
      2'b01: t = -sval(b);
      2'b10: t = sval(a) + sval(b);
      default: begin
        nb_int = -sval(b);
        nb     = nb_int[W-1:0];
        t      = sval(a) + sval(nb);
      end
    endcase
    res = t[W-1:0];
    ovf = (t > MAXV) || (t < MINV);
  endfunction

  function automatic logic [1:0] grant_of(input logic [1:0] v, input int last);
    if (v == 2'b01) return 2'b01;
    if (v == 2'b10) return 2'b10;
    if (v == 2'b11) return (last == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  // phase: 0 waiting for request, 1-2 computing, 3 presenting response
  int m_phase = 0;
  int m_last  = 1;
  int m_id    = 0;
  logic [W-1:0] m_res;
  logic m_ovf;
  int rsp_count = 0;

  initial begin
    logic [1:0] exp_ready;
    int g;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = 0;
        m_last  = 1;
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_id", bus.rsp_id, 0);
        chk("reset_rsp_result", bus.rsp_result, 0);
        chk("reset_rsp_overflow", bus.rsp_overflow, 0);
      end else begin
        exp_ready = (m_phase == 0) ? grant_of(bus.req_valid, m_last) : 2'b00;
        chk("req_ready", bus.req_ready, exp_ready);
        chk("rsp_valid", bus.rsp_valid, (m_phase == 3) ? 1 : 0);
        if (m_phase == 3) begin
          chk("rsp_id", bus.rsp_id, m_id);
          chk("rsp_result", bus.rsp_result, m_res);
          chk("rsp_overflow", bus.rsp_overflow, m_ovf);
        end
        if (m_phase == 0) begin
          if (exp_ready != 2'b00) begin
            g = exp_ready[1] ? 1 : 0;
            ref_op(bus.req_op[g], bus.req_a[g], bus.req_b[g], m_res, m_ovf);
            m_id    = g;
            m_last  = g;
            m_phase = 1;
          end
        end else if (m_phase == 3) begin
          if (bus.rsp_ready) begin
            m_phase = 0;
            rsp_count++;
          end
        end else begin
          m_phase++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int r, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_op[r]    = op;
    bus.req_a[r]     = a;
    bus.req_b[r]     = b;
    bus.req_valid[r] = 1'b1;
  endtask

  task automatic complete_one(input int r, input logic [W-1:0] er, input logic eo, input string nm);
    int waits;
    bit got;
    got = 0;
    waits = 0;
    while (!got && waits < 20) begin
      @(negedge clk);
      waits++;
      if (bus.req_ready[r]) got = 1;
    end
    chk({nm, "_accept_wait"}, waits, 1);
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b0;
    got = 0;
    waits = 0;
    while (!got && waits < 20) begin
      @(negedge clk);
      waits++;
      if (bus.rsp_valid) got = 1;
    end
    chk({nm, "_latency"}, waits - 1, 2);
    chk({nm, "_id"}, bus.rsp_id, r);
    chk({nm, "_result"}, bus.rsp_result, er);
    chk({nm, "_overflow"}, bus.rsp_overflow, eo);
    $display("op %s: req=%0d result=%b ovf=%0d", nm, r, bus.rsp_result, bus.rsp_overflow);
  endtask

  task automatic run_one(input int r, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic eo, input string nm);
    @(posedge clk); #1;
    drive(r, op, a, b);
    complete_one(r, er, eo, nm);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return MIN_BITS;
      2: return MAX_BITS;
      3: return {W{1'b1}};
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] pr;
    logic po;
    int ids[$];
    int waits;
    bit got;
    logic [W-1:0] rec_res;
    logic rec_ovf, rec_id;

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // pin the reference model with hand-computed values
    ref_op(2'b01, 6'b000000, 6'b000001, pr, po); chk("model_neg1", {po, pr}, {1'b0, 6'b111111});
    ref_op(2'b01, 6'b000000, 6'b100000, pr, po); chk("model_negmin", {po, pr}, {1'b1, 6'b100000});
    ref_op(2'b01, 6'b000000, 6'b000000, pr, po); chk("model_neg0", {po, pr}, {1'b0, 6'b000000});
    ref_op(2'b11, 6'b000101, 6'b000111, pr, po); chk("model_sub", {po, pr}, {1'b0, 6'b111110});
    ref_op(2'b10, 6'b011111, 6'b000001, pr, po); chk("model_add", {po, pr}, {1'b1, 6'b100000});
    ref_op(2'b11, 6'b111111, 6'b100000, pr, po); chk("model_submin", {po, pr}, {1'b1, 6'b011111});
    ref_op(2'b00, 6'b010101, 6'b100000, pr, po); chk("model_pass", {po, pr}, {1'b0, 6'b010101});

    #1;
    chk("init_rsp_valid", bus.rsp_valid, 0);
    chk("init_rsp_result", bus.rsp_result, 0);
    repeat (2) @(posedge clk);
    #1;
    // request presented together with reset release: first edge must accept it
    rst_n = 1'b1;
    drive(0, 2'b01, 6'b001100, 6'b000001);
    complete_one(0, 6'b111111, 1'b0, "neg_one");

    run_one(1, 2'b01, 6'b000000, 6'b100000, 6'b100000, 1'b1, "neg_min");
    run_one(1, 2'b01, 6'b000000, 6'b000000, 6'b000000, 1'b0, "neg_zero");
    run_one(0, 2'b11, 6'b000101, 6'b000111, 6'b111110, 1'b0, "sub");
    run_one(1, 2'b10, 6'b011111, 6'b000001, 6'b100000, 1'b1, "add_ovf");
    run_one(0, 2'b11, 6'b111111, 6'b100000, 6'b011111, 1'b1, "sub_min_ovf");
    run_one(1, 2'b11, 6'b000000, 6'b100000, 6'b100000, 1'b0, "sub_min_wrap");
    run_one(0, 2'b00, 6'b010101, 6'b100000, 6'b010101, 1'b0, "pass");

    // response stall: outputs hold and other requests are ignored
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    drive(0, 2'b11, 6'b000101, 6'b000111);
    got = 0;
    waits = 0;
    while (!got && waits < 20) begin
      @(negedge clk); waits++;
      if (bus.req_ready[0]) got = 1;
    end
    chk("stall_accept_wait", waits, 1);
    @(posedge clk); #1;
    drive(1, 2'b10, 6'b000001, 6'b000001);
    got = 0;
    waits = 0;
    while (!got && waits < 20) begin
      @(negedge clk); waits++;
      if (bus.rsp_valid) got = 1;
    end
    rec_res = bus.rsp_result;
    rec_ovf = bus.rsp_overflow;
    rec_id  = bus.rsp_id;
    chk("stall_result", rec_res, 6'b111110);
    chk("stall_id", rec_id, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_hold_result", bus.rsp_result, rec_res);
      chk("stall_hold_ovf", bus.rsp_overflow, rec_ovf);
      chk("stall_hold_id", bus.rsp_id, rec_id);
      chk("stall_ready_low", bus.req_ready, 0);
    end
    $display("op stall: result=%b held for 3 cycles", rec_res);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("stall_release_valid", bus.rsp_valid, 1);
    @(negedge clk);
    chk("stall_idle_valid", bus.rsp_valid, 0);

    // reset while the operation is in its NEG step
    @(posedge clk); #1;
    drive(1, 2'b10, 6'b011111, 6'b000001);
    got = 0;
    waits = 0;
    while (!got && waits < 20) begin
      @(negedge clk); waits++;
      if (bus.req_ready[1]) got = 1;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_rsp_id", bus.rsp_id, 0);
    chk("abort_rsp_result", bus.rsp_result, 0);
    chk("abort_rsp_overflow", bus.rsp_overflow, 0);
    $display("op abort: reset during NEG step");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // both requesters held valid: alternation starting from requester 0
    drive(0, 2'b00, 6'b000011, 6'b000000);
    drive(1, 2'b01, 6'b000000, 6'b000010);
    waits = 0;
    while (ids.size() < 4 && waits < 60) begin
      @(negedge clk); waits++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        ids.push_back(int'(bus.rsp_id));
        $display("op tie: rsp_id=%0d result=%b", bus.rsp_id, bus.rsp_result);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("tie_count", ids.size(), 4);
    while (ids.size() < 4) ids.push_back(-1);
    chk("tie_id0", ids[0], 0);
    chk("tie_id1", ids[1], 1);
    chk("tie_id2", ids[2], 0);
    chk("tie_id3", ids[3], 1);

    // randomized traffic with occasional resets and back-pressure
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      bus.req_valid = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        bus.req_op[i] = 2'($urandom_range(0, 3));
        bus.req_a[i]  = rnd_val();
        bus.req_b[i]  = rnd_val();
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    $display("op random: responses=%0d", rsp_count);
    chk("random_traffic_flowed", (rsp_count > 100) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/complement_scheduler.md
COMPLEMENT_SCHEDULER -- requirements
Module: complement_scheduler

Interface
REQ-001 The block SHALL have parameter W, default 6, the operand/result width in bits.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports req_valid  input  2, req_ready  output  2, one bit per requester i (0,1).
REQ-005 The block SHALL have ports req_op  input  2x2  operation per requester: 00 PASS, 01 NEG, 10 ADD, 11 SUB.
REQ-006 The block SHALL have ports req_a, req_b  input  2xW  operands per requester, two's complement.
REQ-007 The block SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (granted requester), rsp_result  output  W, rsp_overflow  output  1.

Function
REQ-008 The FSM SHALL have states IDLE, NEG, ADD, RESP.
REQ-009 In IDLE: req_ready[i] = grant[i]; all req_ready SHALL be 0 in every other state.
REQ-010 Arbitration SHALL be round-robin: a single valid requester is granted; if both are valid, grant the one not granted last.
REQ-011 The request handshake (valid & ready, rising edge) SHALL capture op, a, b and id, then move IDLE->NEG.
REQ-012 NEG->ADD on the next edge: b_reg <= two's complement of b_reg (~b+1, mod 2^W) for NEG and SUB; unchanged for PASS and ADD.
REQ-013 ADD->RESP on the next edge: result <= a_reg+b_reg (mod 2^W) for ADD/SUB; b_reg for NEG; a_reg for PASS.
REQ-014 In RESP, rsp_valid SHALL be 1, with rsp_id/rsp_result/rsp_overflow held stable until rsp_ready=1; that edge moves RESP->IDLE.
REQ-015 Latency SHALL be: request accepted at edge E0, rsp_valid high from E2; throughput SHALL be at most one operation per 4 cycles when rsp_ready=1.
REQ-016 Overflow for ADD/SUB SHALL be signed overflow: sign(a)==sign(b_reg after NEG step) and sign(result)!=sign(a).
REQ-017 Overflow for NEG SHALL be 1 only for operand 1 followed by W-1 zeros (-2^(W-1)); NEG of 0 gives 0, overflow 0.
REQ-018 Overflow for PASS SHALL be 0.
REQ-019 SUB with b = -2^(W-1) SHALL use the wrapped complement, with overflow computed per REQ-016 on the wrapped value.
REQ-020 req_valid changes outside IDLE SHALL be ignored; no request is dropped or queued internally.

Reset
REQ-021 On rst_n=0, immediately and regardless of clock: state=IDLE; rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0; operand registers 0; last-grant pointer set so requester 0 wins the first tie.
REQ-022 Reset asserted mid-operation SHALL abort the operation with no response produced.
REQ-023 After rst_n rises, the first edge SHALL be able to accept a request.

Structure
REQ-024 A shared package SHALL hold W's default, the op encoding (PASS/NEG/ADD/SUB) and the FSM state enumeration.
REQ-025 The complement datapath SHALL be one sub-module, neg_unit (W-bit ~x+1 plus most-negative detect), instantiated exactly once and shared by both requesters.

Verification
REQ-026 Req0 NEG b=000001 -> rsp_result=111111, overflow=0, rsp_id=0, rsp_valid 2 edges after accept.
REQ-027 Req1 NEG b=100000 -> rsp_result=100000, overflow=1; NEG b=000000 -> 000000, overflow=0.
REQ-028 SUB a=000101, b=000111 -> 111110, overflow=0; ADD a=011111, b=000001 -> 100000, overflow=1.
REQ-029 Both req_valid held high for 4 operations -> rsp_id sequence 0,1,0,1; req_ready never high for both in one cycle.
REQ-030 rsp_ready held 0 for 3 cycles in RESP -> outputs stable, req_ready stays 0, no new accept; on rsp_ready=1 returns to IDLE.
REQ-031 rst_n pulsed low in NEG state -> all outputs 0 asynchronously, no response emitted, next request serviced normally with requester 0 winning a tie.
